// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl: motion sequencer in front of the servo PWM generator.
// Owns the PWM frame timebase, accepts a target angle over valid/ready and
// slews the commanded angle toward it by at most STEP degrees per frame.
// After SETTLE_FRAMES frames at target it pulses done (mirrored on sig_done).
// Optional macro SERVO_SOFT_LIMIT_EN: additionally clamps the accepted target
// into [LIM_LO, LIM_HI]. Without it only the 180 degree clamp applies.
module servo_motion_ctrl #(
  parameter int unsigned FRAME_CYCLES  = 2_000_000,
  parameter logic [8:0]  STEP          = 9'd3,
  parameter logic [8:0]  HOME          = 9'd90,
  parameter logic [3:0]  SETTLE_FRAMES = 4'd5,
  parameter logic [8:0]  LIM_LO        = 9'd0,
  parameter logic [8:0]  LIM_HI        = 9'd180
) (
  input  logic       i_sclk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [8:0] i_cmd_angle,
  output logic       o_cmd_ready,
  output logic [8:0] o_angle,
  output logic       o_frame_tick,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sig_done
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [8:0] MAX_ANGLE = 9'd180;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_frameCnt;
  logic [8:0]       r_angle;
  logic [8:0]       r_target;
  logic [3:0]       r_settleCnt;
  logic             r_cmdReady;
  logic             r_busy;
  logic             r_done;

  logic             w_frameTick;
  logic [8:0]       w_clamp180;
  logic [8:0]       w_cmdTarget;
  logic [8:0]       w_diff;
  logic             w_tgtAbove;
  logic             w_settleLast;

  assign w_frameTick = (r_frameCnt == LAST_CNT);
  assign w_clamp180  = (i_cmd_angle > MAX_ANGLE) ? MAX_ANGLE : i_cmd_angle;

`ifdef SERVO_SOFT_LIMIT_EN
  assign w_cmdTarget = (w_clamp180 < LIM_LO) ? LIM_LO :
                       (w_clamp180 > LIM_HI) ? LIM_HI : w_clamp180;
`else
  assign w_cmdTarget = w_clamp180;
`endif

  // Distance is formed by comparing first so the 9-bit subtract never wraps.
  assign w_tgtAbove   = (r_target > r_angle);
  assign w_diff       = w_tgtAbove ? (r_target - r_angle) : (r_angle - r_target);
  assign w_settleLast = (({1'b0, r_settleCnt} + 5'd1) >= {1'b0, SETTLE_FRAMES});

  // Free-running frame timebase; the tick decodes its last count.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_frameCnt <= '0;
    end else if (w_frameTick) begin
      r_frameCnt <= '0;
    end else begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  // Command FSM: accept in IDLE, slew once per frame in MOVE, then wait out SETTLE.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_angle     <= HOME;
      r_target    <= HOME;
      r_settleCnt <= '0;
      r_cmdReady  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cmd_valid && r_cmdReady) begin
            r_target   <= w_cmdTarget;
            r_state    <= MOVE;
            r_cmdReady <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        MOVE: begin
          if (w_frameTick) begin
            if (w_diff <= STEP) begin
              r_angle     <= r_target;
              r_settleCnt <= '0;
              r_state     <= SETTLE;
            end else if (w_tgtAbove) begin
              r_angle <= r_angle + STEP;
            end else begin
              r_angle <= r_angle - STEP;
            end
          end
        end
        SETTLE: begin
          if (w_frameTick) begin
            if (w_settleLast) begin
              r_done     <= 1'b1;
              r_cmdReady <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_settleCnt <= r_settleCnt + 4'd1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cmdReady <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready  = r_cmdReady;
  assign o_angle      = r_angle;
  assign o_frame_tick = w_frameTick;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sig_done   = r_done;

endmodule
